// File: rtl/mfp_vga_scan_ctrl.sv
// VGA scanout for the 640x480x12 VRAM read port: 640x480@60 timing, linear addressing.
// Address leads pixel output by one tick; colour, syncs, VBLANK and FRAME_START share that delay.
module mfp_vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        EN,
    output logic [18:0] IO_VGA_ADDR,
    input  logic [11:0] IO_VGA_DATA,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VBLANK,
    output logic        FRAME_START
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_hcnt, r_dh;
    logic [VW-1:0] r_vcnt, r_dv;
    logic [18:0]   r_addr_cnt, r_addr;
    logic          r_pvld;
    logic [11:0]   r_rgb;
    logic          r_hs, r_vs, r_vblank, r_fs;

    logic          w_tick, w_h_wrap, w_v_wrap, w_active, w_sof;
    logic [18:0]   w_addr_cur;
    logic          w_d_active, w_hs_n, w_vs_n, w_vblank, w_fs;

    assign w_tick     = EN && (r_div == DIV_LAST);
    assign w_h_wrap   = (r_hcnt == H_LAST);
    assign w_v_wrap   = (r_vcnt == V_LAST);
    assign w_active   = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    assign w_sof      = (r_hcnt == '0) && (r_vcnt == '0);
    // Linear address is a running count, re-seeded at the frame origin instead of y*W+x.
    assign w_addr_cur = w_sof ? '0 : r_addr_cnt;

    // Output-stage decode works on the coordinates captured one tick earlier.
    assign w_d_active = r_pvld && (r_dh < H_ACT) && (r_dv < V_ACT);
    assign w_hs_n     = !(r_pvld && (r_dh >= HS_BEG) && (r_dh <= HS_END));
    assign w_vs_n     = !(r_pvld && (r_dv >= VS_BEG) && (r_dv <= VS_END));
    assign w_vblank   = !r_pvld || (r_dv >= V_ACT);
    assign w_fs       = r_pvld && (r_dh == '0) && (r_dv == '0);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_div      <= '0;
            r_hcnt     <= '0;
            r_vcnt     <= '0;
            r_addr_cnt <= '0;
            r_addr     <= '0;
            r_dh       <= '0;
            r_dv       <= '0;
            r_pvld     <= 1'b0;
            r_rgb      <= '0;
            r_hs       <= 1'b1;
            r_vs       <= 1'b1;
            r_vblank   <= 1'b1;
            r_fs       <= 1'b0;
        end else if (!EN) begin
            r_div      <= '0;
            r_hcnt     <= '0;
            r_vcnt     <= '0;
            r_addr_cnt <= '0;
            r_addr     <= '0;
            r_dh       <= '0;
            r_dv       <= '0;
            r_pvld     <= 1'b0;
            r_rgb      <= '0;
            r_hs       <= 1'b1;
            r_vs       <= 1'b1;
            r_vblank   <= 1'b1;
            r_fs       <= 1'b0;
        end else begin
            r_fs  <= 1'b0;
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_hcnt <= w_h_wrap ? '0 : r_hcnt + 1'b1;
                if (w_h_wrap) begin
                    r_vcnt <= w_v_wrap ? '0 : r_vcnt + 1'b1;
                end
                if (w_active) begin
                    r_addr     <= w_addr_cur;
                    r_addr_cnt <= w_addr_cur + 1'b1;
                end
                r_dh     <= r_hcnt;
                r_dv     <= r_vcnt;
                r_pvld   <= 1'b1;
                r_rgb    <= w_d_active ? IO_VGA_DATA : '0;
                r_hs     <= w_hs_n;
                r_vs     <= w_vs_n;
                r_vblank <= w_vblank;
                r_fs     <= w_fs;
            end
        end
    end

    assign IO_VGA_ADDR = r_addr;
    assign VGA_R       = r_rgb[11:8];
    assign VGA_G       = r_rgb[7:4];
    assign VGA_B       = r_rgb[3:0];
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VBLANK      = r_vblank;
    assign FRAME_START = r_fs;
endmodule
